dcache_assoc: RTL and testbench
===============================

# dcache_assoc

Parametrised N-way set-associative data cache between the MEM stage and the memory arbiter; next generation of the 2-way, 8-byte-line dcache. Lines are 2^WORD_SELECT_BIT bytes and are refilled in multiple 64-bit beats. Victims are chosen by invalid-first then per-set round-robin. Policy is write-through, no-write-allocate, with a single outstanding memory transaction, one-cycle flush and a miss counter.

## Interface
- WORD_SELECT_BIT, 4, log2 line bytes; legal range 3..6; beats per refill NBEAT = 2^(WORD_SELECT_BIT-3)
- INDEX_BIT, 2, log2 sets; legal range 1..8
- NASSOC, 4, ways; power of two, 1..8
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ce  in  1  chip enable
- addr  in  32  byte address; word-aligned
- read_flag  in  1  load request
- read_data  out  32  load data
- write_data  in  32  store data
- write_mask  in  4  byte enables
- write_flag  in  1  store request
- flush  in  1  invalidate all lines
- cache_req_o  out  1  refill beat request
- cache_addr_o  out  32  memory address
- cache_write_o  out  1  write-through request
- cache_write_data_o  out  32  store data to memory
- cache_write_mask_o  out  4  store mask to memory
- cache_rep_i  in  1  one-cycle memory acknowledge
- cache_rep_data_i  in  64  refill beat data
- stallreq  out  1  pipeline stall request
- miss_count_o  out  32  load-miss counter

## Operation
- Address split: tag = addr[31:INDEX_BIT+WORD_SELECT_BIT], index = addr[INDEX_BIT+WORD_SELECT_BIT-1:WORD_SELECT_BIT], offset = low WORD_SELECT_BIT bits.
- Storage per way and set: valid, tag, and line bytes. Per set: a victim pointer of log2(NASSOC) bits.
- Byte order is big-endian within a word. read_data = {b[o], b[o+1], b[o+2], b[o+3]} with o = offset & ~3. write_mask[3] writes b[o] from write_data[31:24], and so on down to mask[0] writing b[o+3].
- Hit = any way valid with matching tag. At most one way may hit.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - ce=0 or no request: stallreq=0 and read_data=0.
  - write_flag has priority over read_flag.
  - Write, hit or miss: go to WRITE.
  - Read hit: read_data is driven combinationally from the hit way and stallreq=0.
  - Read miss: stallreq=1. Latch the victim: the lowest-numbered invalid way, else the set's victim pointer. Increment miss_count_o, which wraps. Go to REFILL with beat=0.
- REFILL:
  - cache_req_o=1 and cache_addr_o={tag, index, beat, 3'b000}; both are held until cache_rep_i.
  - On cache_rep_i, cache_rep_data_i[8j+7:8j] is stored into victim byte 8*beat+j.
  - On the last beat, write the tag, set valid, advance the set's victim pointer modulo NASSOC, and go to IDLE. The request then hits on the next cycle.
  - The victim's valid bit is cleared on REFILL entry.
- WRITE:
  - cache_write_o=1, cache_addr_o=addr, data and mask are passed through, and stallreq=1.
  - On cache_rep_i: if hit, update the masked bytes in the hit way; a miss allocates nothing. stallreq=0 in that same cycle (combinational), then go to IDLE.
- cache_write_data_o and cache_write_mask_o are continuous copies of write_data and write_mask.
- flush:
  - In IDLE: all valid bits are cleared at the next edge and victim pointers are reset to 0. Takes priority over a request in that cycle; stallreq=1 that cycle.
  - In REFILL or WRITE: the flush is held pending until the return to IDLE.
- ce falling in REFILL or WRITE: return to IDLE at the next edge and leave the victim invalid. A later cache_rep_i is ignored.
- cache_rep_i in IDLE is ignored.

## Timing
- Reset while rst=0, asynchronous:
  - All valid bits=0, victim pointers=0, state=IDLE, miss_count_o=0.
  - read_data=0, cache_req_o=0, cache_addr_o=0, cache_write_o=0, stallreq=0.
  - Reset mid-refill or mid-write abandons the transaction.
- Read hit: 0 added cycles.
- Read miss: 1 IDLE cycle + sum of beat latencies + 1 cycle for the hit replay. With a memory that acks the cycle after the request and NBEAT=2, that is 5 cycles with stallreq=1 before data is returned.
- Write: stallreq=1 from the request cycle until the cycle cache_rep_i is high.
- Beat requests are not pipelined: cache_req_o drops for 0 cycles between beats. The address changes on the edge after the ack.

## Test plan
- Reset, then read 0x00000040 with memory beats 0x1122334455667788 and 0x99AABBCCDDEEFF00 -> two requests at 0x40 and 0x48. read_data=0x88776655, miss_count_o=1, and a re-read hits with stallreq=0.
- Fill 5 tags into set 0 with NASSOC=4 -> the fifth fill evicts way 0. Re-reading the first tag misses and the others hit.
- Write 0xDEADBEEF with mask 4'b0011 to a cached word holding 0x88776655 -> cache_write_o held until ack. A subsequent read returns 0x8877BEEF.
- Write to an uncached address -> cache_write_o only, no refill, and a later read of that address misses.
- Flush while a line is valid -> the next read misses. Flush asserted during REFILL is honored after the line lands.
- Assert rst=0 mid-REFILL after beat 0 -> outputs 0 immediately. The post-reset read misses and requests beat 0 again.

Source files
------------

// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - N-way set-associative write-through data cache with multi-beat refill
module dcache_assoc #(
    parameter int WORD_SELECT_BIT = 4,
    parameter int INDEX_BIT       = 2,
    parameter int NASSOC          = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] addr,
    input  logic        read_flag,
    output logic [31:0] read_data,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_mask,
    input  logic        write_flag,
    input  logic        flush,
    output logic        cache_req_o,
    output logic [31:0] cache_addr_o,
    output logic        cache_write_o,
    output logic [31:0] cache_write_data_o,
    output logic [3:0]  cache_write_mask_o,
    input  logic        cache_rep_i,
    input  logic [63:0] cache_rep_data_i,
    output logic        stallreq,
    output logic [31:0] miss_count_o
);
    localparam int NSET       = 1 << INDEX_BIT;
    localparam int LINE_BYTES = 1 << WORD_SELECT_BIT;
    localparam int NBEAT      = 1 << (WORD_SELECT_BIT - 3);
    localparam int TAG_BIT    = 32 - INDEX_BIT - WORD_SELECT_BIT;
    localparam int WAY_BIT    = (NASSOC > 1) ? $clog2(NASSOC) : 1;
    localparam int BEAT_BIT   = (WORD_SELECT_BIT > 3) ? WORD_SELECT_BIT - 3 : 1;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
    state_t state;

    logic [NASSOC-1:0]   valid      [NSET];
    logic [WAY_BIT-1:0]  victim_ptr [NSET];
    logic [TAG_BIT-1:0]  tags       [NASSOC][NSET];
    logic [7:0]          data       [NASSOC][NSET][LINE_BYTES];

    logic [TAG_BIT-1:0]         req_tag;
    logic [INDEX_BIT-1:0]       req_index;
    logic [WAY_BIT-1:0]         req_way;
    logic [BEAT_BIT-1:0]        beat;
    logic                       flush_pend;

    logic [TAG_BIT-1:0]         tag;
    logic [INDEX_BIT-1:0]       index;
    logic [WORD_SELECT_BIT-1:0] off;
    logic                       hit, free_found;
    logic [WAY_BIT-1:0]         hit_way, free_way, victim;
    logic [31:0]                rd_word;
    logic                       flush_any, last_beat, refill_we, write_we;

    assign tag   = addr[31 -: TAG_BIT];
    assign index = addr[INDEX_BIT+WORD_SELECT_BIT-1 : WORD_SELECT_BIT];
    assign off   = addr[WORD_SELECT_BIT-1:0] & ~WORD_SELECT_BIT'(3);

    assign cache_write_data_o = write_data;
    assign cache_write_mask_o = write_mask;

    assign flush_any = flush || flush_pend;
    assign last_beat = (beat == BEAT_BIT'(NBEAT - 1));
    assign refill_we = (state == REFILL) && ce && cache_rep_i;
    assign write_we  = (state == WRITE) && ce && cache_rep_i && hit;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NASSOC; w++) begin
            if (valid[index][w] && tags[w][index] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_BIT'(w);
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int w = NASSOC - 1; w >= 0; w--) begin
            if (!valid[index][w]) begin
                free_found = 1'b1;
                free_way   = WAY_BIT'(w);
            end
        end
        victim = free_found ? free_way : victim_ptr[index];
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 4; k++)
            rd_word[31-8*k -: 8] = data[hit_way][index][off + WORD_SELECT_BIT'(k)];
    end

    always_comb begin
        read_data     = '0;
        stallreq      = 1'b0;
        cache_req_o   = 1'b0;
        cache_write_o = 1'b0;
        cache_addr_o  = '0;
        case (state)
            IDLE: begin
                if (flush_any)
                    stallreq = 1'b1;
                else if (ce && write_flag)
                    stallreq = 1'b1;
                else if (ce && read_flag) begin
                    if (hit) read_data = rd_word;
                    else     stallreq  = 1'b1;
                end
            end
            REFILL: begin
                cache_req_o  = 1'b1;
                stallreq     = 1'b1;
                cache_addr_o = {req_tag, req_index, {WORD_SELECT_BIT{1'b0}}} | (32'(beat) << 3);
            end
            WRITE: begin
                cache_write_o = 1'b1;
                cache_addr_o  = addr;
                stallreq      = !cache_rep_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            req_tag      <= '0;
            req_index    <= '0;
            req_way      <= '0;
            beat         <= '0;
            flush_pend   <= 1'b0;
            miss_count_o <= '0;
            for (int s = 0; s < NSET; s++) begin
                valid[s]      <= '0;
                victim_ptr[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (flush_any) begin
                        flush_pend <= 1'b0;
                        for (int s = 0; s < NSET; s++) begin
                            valid[s]      <= '0;
                            victim_ptr[s] <= '0;
                        end
                    end else if (ce && write_flag) begin
                        state <= WRITE;
                    end else if (ce && read_flag && !hit) begin
                        miss_count_o         <= miss_count_o + 32'd1;
                        req_tag              <= tag;
                        req_index            <= index;
                        req_way              <= victim;
                        beat                 <= '0;
                        valid[index][victim] <= 1'b0;
                        state                <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush) flush_pend <= 1'b1;
                    if (!ce) begin
                        state <= IDLE;
                    end else if (cache_rep_i) begin
                        if (last_beat) begin
                            valid[req_index][req_way] <= 1'b1;
                            victim_ptr[req_index] <= (victim_ptr[req_index] == WAY_BIT'(NASSOC - 1)) ?
                                                     '0 : victim_ptr[req_index] + WAY_BIT'(1);
                            state <= IDLE;
                        end else begin
                            beat <= beat + BEAT_BIT'(1);
                        end
                    end
                end
                WRITE: begin
                    if (flush) flush_pend <= 1'b1;
                    if (!ce || cache_rep_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage needs no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (refill_we) begin
            for (int j = 0; j < 8; j++)
                data[req_way][req_index][WORD_SELECT_BIT'(8 * int'(beat) + j)] <= cache_rep_data_i[8*j +: 8];
            if (last_beat) tags[req_way][req_index] <= req_tag;
        end
        if (write_we) begin
            for (int k = 0; k < 4; k++)
                if (write_mask[3-k])
                    data[hit_way][index][off + WORD_SELECT_BIT'(k)] <= write_data[31-8*k -: 8];
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// tb/tb_dcache_assoc.sv - scoreboard bench for dcache_assoc
module tb_dcache_assoc;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic [31:0] addr = '0;
    logic        read_flag = 1'b0;
    logic [31:0] read_data;
    logic [31:0] write_data = '0;
    logic [3:0]  write_mask = '0;
    logic        write_flag = 1'b0;
    logic        flush = 1'b0;
    logic        cache_req_o;
    logic [31:0] cache_addr_o;
    logic        cache_write_o;
    logic [31:0] cache_write_data_o;
    logic [3:0]  cache_write_mask_o;
    logic        cache_rep_i = 1'b0;
    logic [63:0] cache_rep_data_i = '0;
    logic        stallreq;
    logic [31:0] miss_count_o;

    int checks = 0;
    int errors = 0;
    int exp_miss = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    dcache_assoc #(.WORD_SELECT_BIT(4), .INDEX_BIT(2), .NASSOC(4)) dut (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .read_flag(read_flag),
        .read_data(read_data), .write_data(write_data), .write_mask(write_mask),
        .write_flag(write_flag), .flush(flush), .cache_req_o(cache_req_o),
        .cache_addr_o(cache_addr_o), .cache_write_o(cache_write_o),
        .cache_write_data_o(cache_write_data_o), .cache_write_mask_o(cache_write_mask_o),
        .cache_rep_i(cache_rep_i), .cache_rep_data_i(cache_rep_data_i),
        .stallreq(stallreq), .miss_count_o(miss_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_beat(input logic [31:0] a);
        if (a == 32'h40) return 64'h1122334455667788;
        if (a == 32'h48) return 64'h99AABBCCDDEEFF00;
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [63:0] b;
        int k;
        b = mem_beat({a[31:3], 3'b000});
        k = a[2] ? 4 : 0;
        return {b[8*k +: 8], b[8*(k+1) +: 8], b[8*(k+2) +: 8], b[8*(k+3) +: 8]};
    endfunction

    // Expect a miss on line address a: two beat requests, one counted miss.
    task automatic expect_fill(input logic [31:0] a);
        exp_addr_q.push_back({a[31:4], 4'h0});
        exp_addr_q.push_back({a[31:4], 4'h8});
        exp_miss++;
    endtask

    task automatic do_read(input logic [31:0] a, input int flush_at, output int stalls);
        logic        ack_next;
        logic [31:0] ack_addr;
        logic        done;
        logic [31:0] want;
        ack_next = 1'b0; ack_addr = '0; done = 1'b0; stalls = 0;
        ce = 1'b1; read_flag = 1'b1; addr = a;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (!stallreq) begin
                done = 1'b1;
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_data_unexpected addr=%h got=%h expected=none", a, read_data);
                end else begin
                    want = exp_data_q.pop_front();
                    if (read_data !== want) begin
                        errors++;
                        $display("FAIL read_data addr=%h got=%h expected=%h", a, read_data, want);
                    end
                end
            end else begin
                stalls++;
                if (cache_req_o && !cache_rep_i) begin
                    ack_next = 1'b1;
                    ack_addr = cache_addr_o;
                    checks++;
                    if (exp_addr_q.size() == 0) begin
                        errors++;
                        $display("FAIL refill_unexpected got=%h expected=none", cache_addr_o);
                    end else begin
                        want = exp_addr_q.pop_front();
                        if (cache_addr_o !== want) begin
                            errors++;
                            $display("FAIL refill_addr got=%h expected=%h", cache_addr_o, want);
                        end
                    end
                end
                @(posedge clk); #1;
                cache_rep_i      = ack_next;
                cache_rep_data_i = ack_next ? mem_beat(ack_addr) : '0;
                ack_next         = 1'b0;
                flush            = (c + 1 == flush_at);
            end
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL read_timeout addr=%h got=stalled expected=data", a);
        end
        @(posedge clk); #1;
        read_flag = 1'b0; ce = 1'b0; cache_rep_i = 1'b0; flush = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            output int stalls, output int wcycles, output int nreq);
        logic ack_next;
        logic done;
        ack_next = 1'b0; done = 1'b0; stalls = 0; wcycles = 0; nreq = 0;
        ce = 1'b1; write_flag = 1'b1; addr = a; write_data = d; write_mask = m;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (cache_req_o) nreq++;
            if (cache_write_o) begin
                wcycles++;
                checks++;
                if (cache_addr_o !== a || cache_write_data_o !== d || cache_write_mask_o !== m) begin
                    errors++;
                    $display("FAIL write_bus got=%h/%h/%h expected=%h/%h/%h",
                             cache_addr_o, cache_write_data_o, cache_write_mask_o, a, d, m);
                end
            end
            if (!stallreq) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (cache_write_o && !cache_rep_i) ack_next = 1'b1;
                @(posedge clk); #1;
                cache_rep_i = ack_next;
                ack_next    = 1'b0;
            end
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL write_timeout addr=%h got=stalled expected=ack", a);
        end
        @(posedge clk); #1;
        write_flag = 1'b0; ce = 1'b0; cache_rep_i = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (stallreq !== 1'b1) begin
            errors++;
            $display("FAIL flush_stall got=%b expected=1", stallreq);
        end
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic check_misses(input string name);
        checks++;
        if (miss_count_o !== 32'(exp_miss)) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, miss_count_o, exp_miss);
        end
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending_refills got=%0d expected=0", name, exp_addr_q.size());
            exp_addr_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (read_data !== '0 || cache_req_o !== 1'b0 || cache_addr_o !== '0 ||
            cache_write_o !== 1'b0 || stallreq !== 1'b0 || miss_count_o !== '0) begin
            errors++;
            $display("FAIL %s got=%h/%b/%h/%b/%b/%0d expected=0/0/0/0/0/0", name, read_data,
                     cache_req_o, cache_addr_o, cache_write_o, stallreq, miss_count_o);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset_outputs");
        rst = 1'b1;
        @(posedge clk); #1;
        exp_miss = 0;
    endtask

    task automatic test_read_miss();
        int st;
        expect_fill(32'h40);
        exp_data_q.push_back(32'h88776655);
        do_read(32'h40, -1, st);
        check_int("read_miss_stalls", st, 5);
        exp_data_q.push_back(32'h88776655);
        do_read(32'h40, -1, st);
        check_int("read_hit_stalls", st, 0);
        check_misses("read_miss_count");
    endtask

    task automatic test_write_hit();
        int st, wc, nr;
        do_write(32'h40, 32'hDEADBEEF, 4'b0011, st, wc, nr);
        check_int("write_hit_stalls", st, 2);
        check_int("write_hit_write_cycles", wc, 2);
        check_int("write_hit_refills", nr, 0);
        exp_data_q.push_back(32'h8877BEEF);
        do_read(32'h40, -1, st);
        check_int("write_hit_reread_stalls", st, 0);
    endtask

    task automatic test_write_miss();
        int st, wc, nr;
        do_write(32'h1010, 32'h12345678, 4'b1111, st, wc, nr);
        check_int("write_miss_write_cycles", wc, 2);
        check_int("write_miss_refills", nr, 0);
        expect_fill(32'h1010);
        exp_data_q.push_back(exp_word(32'h1010));
        do_read(32'h1010, -1, st);
        check_int("write_miss_read_stalls", st, 5);
        check_misses("write_miss_count");
    endtask

    task automatic test_eviction();
        int st;
        do_flush();
        for (int t = 1; t <= 5; t++) begin
            expect_fill(32'(t) << 6);
            exp_data_q.push_back(exp_word(32'(t) << 6));
            do_read(32'(t) << 6, -1, st);
            check_int("evict_fill_stalls", st, 5);
        end
        for (int t = 2; t <= 5; t++) begin
            exp_data_q.push_back(exp_word((32'(t) << 6) | 32'h4));
            do_read((32'(t) << 6) | 32'h4, -1, st);
            check_int("evict_survivor_stalls", st, 0);
        end
        expect_fill(32'h40);
        exp_data_q.push_back(exp_word(32'h40));
        do_read(32'h40, -1, st);
        check_int("evict_victim_stalls", st, 5);
        check_misses("evict_miss_count");
    endtask

    task automatic test_flush();
        int st;
        expect_fill(32'h200);
        exp_data_q.push_back(exp_word(32'h200));
        do_read(32'h200, -1, st);
        exp_data_q.push_back(exp_word(32'h208));
        do_read(32'h208, -1, st);
        check_int("flush_prehit_stalls", st, 0);
        do_flush();
        expect_fill(32'h208);
        exp_data_q.push_back(exp_word(32'h208));
        do_read(32'h208, -1, st);
        check_int("flush_reread_stalls", st, 5);
        check_misses("flush_miss_count");
    endtask

    task automatic test_flush_during_refill();
        int st;
        expect_fill(32'h240);
        expect_fill(32'h240);
        exp_data_q.push_back(exp_word(32'h240));
        do_read(32'h240, 2, st);
        check_int("flush_refill_stalls", st, 11);
        check_misses("flush_refill_miss_count");
    endtask

    task automatic test_reset_mid_refill();
        int st;
        ce = 1'b1; read_flag = 1'b1; addr = 32'h280;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (cache_req_o !== 1'b1 || cache_addr_o !== 32'h280) begin
            errors++;
            $display("FAIL mid_refill_req got=%b/%h expected=1/00000280", cache_req_o, cache_addr_o);
        end
        @(posedge clk); #1;
        cache_rep_i = 1'b1; cache_rep_data_i = mem_beat(32'h280);
        @(posedge clk); #1;
        cache_rep_i = 1'b0;
        ce = 1'b0; read_flag = 1'b0;
        rst = 1'b0;
        #1;
        check_idle_outputs("mid_refill_reset_outputs");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_miss = 0;
        expect_fill(32'h280);
        exp_data_q.push_back(exp_word(32'h280));
        do_read(32'h280, -1, st);
        check_int("post_reset_stalls", st, 5);
        check_misses("post_reset_miss_count");
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_write_miss();
        test_eviction();
        test_flush();
        test_flush_during_refill();
        test_reset_mid_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
